// File: rtl/types_pkg.sv
// rtl/types_pkg.sv - shared constants and types for the fetch front end.
package types_pkg;
  localparam int XLEN_DEF    = 32;
  localparam int FETCH_DEPTH = 4;

  typedef logic [XLEN_DEF-1:0] DATA_BUS;

  typedef struct packed {
    DATA_BUS instr;
    DATA_BUS pc;
  } fq_entry_t;
endpackage

// File: rtl/fq_fifo.sv
// rtl/fq_fifo.sv - synchronous FIFO with flush and explicit occupancy count.
// Head entry is read straight from storage, so rdata has zero read latency.
module fq_fifo
  import types_pkg::*;
#(
  parameter int  DEPTH = FETCH_DEPTH,
  parameter type T     = fq_entry_t
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     flush,
  input  logic                     push,
  input  T                         wdata,
  input  logic                     pop,
  output T                         rdata,
  output logic [$clog2(DEPTH):0]   count,
  output logic                     empty
);
  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  T              mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, rd_ptr_q;
  logic [CW-1:0] count_q;

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      for (int i = 0; i < DEPTH; i++) mem_q[i] <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push) begin
        mem_q[wr_ptr_q] <= wdata;
        wr_ptr_q        <= wr_ptr_q + 1'b1;
      end
      if (pop) rd_ptr_q <= rd_ptr_q + 1'b1;
      // Simultaneous push and pop leaves occupancy unchanged, even when full.
      count_q <= count_q + CW'(push) - CW'(pop);
    end
  end

  assign rdata = mem_q[rd_ptr_q];
  assign count = count_q;
  assign empty = (count_q == '0);
endmodule

// File: rtl/fetch_queue.sv
// rtl/fetch_queue.sv - instruction fetch front end: PC, credit-limited imem
// requests, in-order response buffering and redirect with stale-response drop.
module fetch_queue
  import types_pkg::*;
#(
  parameter int               XLEN     = XLEN_DEF,
  parameter int               DEPTH    = FETCH_DEPTH,
  parameter logic [XLEN-1:0]  RESET_PC = '0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     redirect_valid,
  input  logic [XLEN-1:0]          redirect_pc,
  output logic                     imem_req_valid,
  input  logic                     imem_req_ready,
  output logic [XLEN-1:0]          imem_addr,
  input  logic                     imem_rsp_valid,
  input  logic [XLEN-1:0]          imem_rsp_data,
  output logic                     instr_valid,
  input  logic                     instr_ready,
  output logic [XLEN-1:0]          instr,
  output logic [XLEN-1:0]          instr_pc,
  output logic [$clog2(DEPTH):0]   count
);
  localparam int CW = $clog2(DEPTH) + 1;

  typedef struct packed {
    logic [XLEN-1:0] instr;
    logic [XLEN-1:0] pc;
  } entry_t;

  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  logic [XLEN-1:0] rsp_pc_q, rsp_pc_d;
  logic [CW-1:0]   in_flight_q, in_flight_d;
  logic [CW-1:0]   drop_cnt_q, drop_cnt_d;
  logic [CW-1:0]   fifo_count;
  logic [CW:0]     credit_used;
  logic            fifo_empty, req_fire, rsp_drop, rsp_push, deq;
  logic [XLEN-1:0] redirect_base;
  logic [1:0]      unused_redirect_lsbs;
  entry_t          wr_entry, head;

  assign redirect_base        = {redirect_pc[XLEN-1:2], 2'b00};
  assign unused_redirect_lsbs = redirect_pc[1:0];

  // Every outstanding request owns a FIFO slot, so responses can never overflow.
  assign credit_used    = {1'b0, fifo_count} + {1'b0, in_flight_q};
  assign imem_req_valid = rst && !redirect_valid && (credit_used < (CW+1)'(DEPTH));
  assign imem_addr      = fetch_pc_q;
  assign req_fire       = imem_req_valid && imem_req_ready;

  assign rsp_drop = imem_rsp_valid && (drop_cnt_q != '0);
  assign rsp_push = imem_rsp_valid && (drop_cnt_q == '0) && !redirect_valid;

  assign instr_valid = !fifo_empty && !redirect_valid;
  assign deq         = instr_valid && instr_ready;

  assign wr_entry = '{instr: imem_rsp_data, pc: rsp_pc_q};

  always_comb begin
    fetch_pc_d  = fetch_pc_q;
    rsp_pc_d    = rsp_pc_q;
    drop_cnt_d  = drop_cnt_q;
    in_flight_d = in_flight_q + CW'(req_fire) - CW'(imem_rsp_valid);
    if (redirect_valid) begin
      // Everything still outstanding after this cycle belongs to the old stream.
      fetch_pc_d = redirect_base;
      rsp_pc_d   = redirect_base;
      drop_cnt_d = in_flight_q - CW'(imem_rsp_valid);
    end else begin
      if (req_fire) fetch_pc_d = fetch_pc_q + XLEN'(4);
      if (rsp_push) rsp_pc_d = rsp_pc_q + XLEN'(4);
      if (rsp_drop) drop_cnt_d = drop_cnt_q - 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_pc_q  <= RESET_PC;
      rsp_pc_q    <= RESET_PC;
      in_flight_q <= '0;
      drop_cnt_q  <= '0;
    end else begin
      fetch_pc_q  <= fetch_pc_d;
      rsp_pc_q    <= rsp_pc_d;
      in_flight_q <= in_flight_d;
      drop_cnt_q  <= drop_cnt_d;
    end
  end

  fq_fifo #(
    .DEPTH (DEPTH),
    .T     (entry_t)
  ) u_fifo (
    .clk   (clk),
    .rst   (rst),
    .flush (redirect_valid),
    .push  (rsp_push),
    .wdata (wr_entry),
    .pop   (deq),
    .rdata (head),
    .count (fifo_count),
    .empty (fifo_empty)
  );

  assign instr    = head.instr;
  assign instr_pc = head.pc;
  assign count    = fifo_count;
endmodule

// File: tb/tb_fetch_queue.sv
// tb/tb_fetch_queue.sv - directed bench for fetch_queue with a latency-modelled imem.
module tb_fetch_queue;
  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_valid;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready;
  logic [31:0] imem_addr;
  logic        imem_rsp_valid;
  logic [31:0] imem_rsp_data;
  logic        instr_valid;
  logic        instr_ready;
  logic [31:0] instr;
  logic [31:0] instr_pc;
  logic [2:0]  count;

  int          n_cmp = 0;
  int          n_bad = 0;
  int          cyc, lat, accepts, pops, first_pop_cyc;
  logic [31:0] exp_pc, exp_req, first_pop_pc;
  logic [31:0] pend_addr [$];
  int          pend_due [$];
  bit          rsp_now;

  fetch_queue #(.XLEN(32), .DEPTH(4), .RESET_PC(32'h0)) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_valid (redirect_valid),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_addr      (imem_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .instr_valid    (instr_valid),
    .instr_ready    (instr_ready),
    .instr          (instr),
    .instr_pc       (instr_pc),
    .count          (count)
  );

  always #5 clk = ~clk;

  function automatic logic [31:0] word_of(input logic [31:0] a);
    return ~a ^ 32'h1234_0000;
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got 0x%08h want 0x%08h (cyc %0d)", tag, obs, exp, cyc);
    end
  endtask

  // One clock cycle, entered and left just after the falling edge.
  task automatic tick();
    int used;
    rsp_now = 1'b0;
    if (pend_addr.size() > 0 && pend_due[0] <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = word_of(pend_addr[0]);
      rsp_now        = 1'b1;
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = '0;
    end
    #1;
    used = int'(count) + pend_addr.size();
    chk("credit", (used <= 4) ? 32'd1 : 32'd0, 32'd1);
    if (instr_valid && instr_ready) begin
      chk("instr_pc", instr_pc, exp_pc);
      chk("instr", instr, word_of(exp_pc));
      if (pops == 0) begin
        first_pop_pc  = instr_pc;
        first_pop_cyc = cyc;
      end
      pops++;
      exp_pc += 32'd4;
    end
    if (imem_req_valid && imem_req_ready) begin
      chk("req_addr", imem_addr, exp_req);
      pend_addr.push_back(imem_addr);
      pend_due.push_back(cyc + lat);
      accepts++;
      exp_req += 32'd4;
    end
    if (redirect_valid) begin
      chk("redir_no_req", {31'd0, imem_req_valid}, 32'd0);
      chk("redir_no_deq", {31'd0, instr_valid}, 32'd0);
      exp_pc  = {redirect_pc[31:2], 2'b00};
      exp_req = {redirect_pc[31:2], 2'b00};
    end
    @(posedge clk);
    cyc++;
    if (rsp_now) begin
      void'(pend_addr.pop_front());
      void'(pend_due.pop_front());
    end
    @(negedge clk);
  endtask

  task automatic do_reset();
    rst            = 1'b0;
    redirect_valid = 1'b0;
    redirect_pc    = '0;
    imem_req_ready = 1'b1;
    instr_ready    = 1'b1;
    imem_rsp_valid = 1'b0;
    imem_rsp_data  = '0;
    repeat (2) @(negedge clk);
    pend_addr.delete();
    pend_due.delete();
    rst     = 1'b1;
    cyc     = 0;
    exp_pc  = 32'h0;
    exp_req = 32'h0;
    pops    = 0;
    accepts = 0;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    rst = 1'b1; redirect_valid = 1'b0; redirect_pc = '0; imem_req_ready = 1'b1;
    instr_ready = 1'b1; imem_rsp_valid = 1'b0; imem_rsp_data = '0;
    cyc = 0; lat = 1; accepts = 0; pops = 0; first_pop_cyc = -1;
    first_pop_pc = '0; exp_pc = '0; exp_req = '0;
    #1 rst = 1'b0;
    #2;
    chk("rst_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("rst_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("rst_count", {29'd0, count}, 32'd0);
    chk("rst_instr", instr, 32'd0);
    chk("rst_instr_pc", instr_pc, 32'd0);

    // Streaming at latency 1 with decode always ready.
    do_reset();
    lat = 1;
    repeat (10) tick();
    chk("t1_first_cyc", first_pop_cyc, 32'd2);
    chk("t1_first_pc", first_pop_pc, 32'h0);
    chk("t1_accepts", accepts, 32'd10);
    chk("t1_pops", pops, 32'd8);

    // Decode stalled: credit limit, then one pop frees exactly one request.
    do_reset();
    lat = 1;
    instr_ready = 1'b0;
    repeat (8) tick();
    chk("t2_accepts", accepts, 32'd4);
    chk("t2_count_full", {29'd0, count}, 32'd4);
    chk("t2_req_low", {31'd0, imem_req_valid}, 32'd0);
    instr_ready = 1'b1;
    tick();
    instr_ready = 1'b0;
    accepts = 0;
    repeat (6) tick();
    chk("t2_one_more", accepts, 32'd1);
    chk("t2_count_refill", {29'd0, count}, 32'd4);

    // Latency 3, three in flight, redirect to 0x100.
    do_reset();
    lat = 3;
    repeat (3) tick();
    chk("t3_inflight", pend_addr.size(), 32'd3);
    redirect_valid = 1'b1;
    redirect_pc    = 32'h100;
    pops = 0;
    tick();
    redirect_valid = 1'b0;
    repeat (12) tick();
    chk("t3_first_pc", first_pop_pc, 32'h100);
    chk("t3_enough_pops", (pops >= 2) ? 32'd1 : 32'd0, 32'd1);
    chk("t3_drop_idle", {29'd0, dut.drop_cnt_q}, 32'd0);

    // Unaligned redirect target is forced to a word boundary.
    do_reset();
    lat = 1;
    repeat (4) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h203;
    pops = 0;
    tick();
    redirect_valid = 1'b0;
    #1;
    chk("t4_req_valid", {31'd0, imem_req_valid}, 32'd1);
    chk("t4_req_addr", imem_addr, 32'h200);
    repeat (6) tick();
    chk("t4_first_pc", first_pop_pc, 32'h200);

    // Back-to-back redirects with a stale response landing on the second.
    do_reset();
    lat = 2;
    repeat (5) tick();
    redirect_valid = 1'b1;
    redirect_pc    = 32'h300;
    tick();
    redirect_pc    = 32'h400;
    chk("t5_stale_lands", (pend_addr.size() > 0 && pend_due[0] <= cyc) ? 32'd1 : 32'd0, 32'd1);
    pops = 0;
    tick();
    redirect_valid = 1'b0;
    repeat (8) tick();
    chk("t5_first_pc", first_pop_pc, 32'h400);
    chk("t5_pops", (pops >= 3) ? 32'd1 : 32'd0, 32'd1);
    chk("t5_drop_zero", {29'd0, dut.drop_cnt_q}, 32'd0);

    // Asynchronous reset mid-stream with three entries queued.
    do_reset();
    lat = 1;
    instr_ready = 1'b0;
    repeat (4) tick();
    chk("t6_count3", {29'd0, count}, 32'd3);
    #2;
    rst = 1'b0;
    imem_rsp_valid = 1'b0;
    #1;
    chk("t6_req_valid", {31'd0, imem_req_valid}, 32'd0);
    chk("t6_instr_valid", {31'd0, instr_valid}, 32'd0);
    chk("t6_count", {29'd0, count}, 32'd0);
    chk("t6_instr", instr, 32'd0);
    chk("t6_instr_pc", instr_pc, 32'd0);
    @(negedge clk);
    pend_addr.delete();
    pend_due.delete();
    rst = 1'b1;
    cyc = 0; exp_pc = 32'h0; exp_req = 32'h0; pops = 0; accepts = 0;
    instr_ready = 1'b1;
    repeat (4) tick();
    chk("t6_restart_pc", first_pop_pc, 32'h0);
    chk("t6_accepts", accepts, 32'd4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
